// File: rtl/dmem_copy_pkg.sv
// dmem_copy_pkg: shared state encoding and sizing constants for the dmem copy engine
package dmem_copy_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;
  localparam int WORD_BYTES = 4;
  localparam int MAX_WORDS  = 64;
  localparam int LEN_W      = 7;
endpackage

// File: rtl/dmem_copy_addr_gen.sv
// dmem_copy_addr_gen: latched src/dst/len, word counter and src/dst+4*i address adders with last-word flag
module dmem_copy_addr_gen #(
  parameter int AW    = 32,
  parameter int LEN_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic             nxt_i,
  input  logic [AW-1:0]    src_i,
  input  logic [AW-1:0]    dst_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [AW-1:0]    src_a_o,
  output logic [AW-1:0]    dst_a_o,
  output logic             last_o
);
  import dmem_copy_pkg::WORD_BYTES;
  logic [AW-1:0]    src_q, dst_q, off;
  logic [LEN_W-1:0] len_q, i_q, idx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      i_q   <= '0;
    end else if (load_i) begin
      src_q <= src_i;
      dst_q <= dst_i;
      len_q <= len_i;
      i_q   <= '0;
    end else if (inc_i) begin
      i_q <= i_q + LEN_W'(1);
    end
  // nxt_i selects word i+1 so the FSM can register the address of the state it is entering
  assign idx     = nxt_i ? i_q + LEN_W'(1) : i_q;
  assign off     = AW'(idx) * AW'(WORD_BYTES);
  assign src_a_o = src_q + off;
  assign dst_a_o = dst_q + off;
  assign last_o  = (i_q + LEN_W'(1)) == len_q;
endmodule

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine: word-block copy master on the dmem port, two cycles per word
// Optional COPY_FILL_EN adds a constant-fill mode (fill/fill_value ports, one cycle per word)
module dmem_copy_engine #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int LEN_W = dmem_copy_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    src_addr,
  input  logic [AW-1:0]    dst_addr,
  input  logic [LEN_W-1:0] len,
`ifdef COPY_FILL_EN
  input  logic             fill,
  input  logic [DW-1:0]    fill_value,
`endif
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             memwrite,
  output logic [AW-1:0]    dataaddr,
  output logic [DW-1:0]    writedata,
  input  logic [DW-1:0]    readdata
);
  import dmem_copy_pkg::*;
  state_e          state_q;
  logic            busy_q, done_q, err_q, memwrite_q;
  logic [AW-1:0]   dataaddr_q;
  logic [DW-1:0]   writedata_q;
  logic [AW-1:0]   src_a, dst_a;
  logic            last, bad, accept;
  logic            fill_go, fill_run;
  logic [DW-1:0]   fill_word;
  assign accept = state_q == IDLE && start;
`ifdef COPY_FILL_EN
  logic fill_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) fill_q <= 1'b0;
    else if (accept) fill_q <= fill;
  assign fill_go   = fill;
  assign fill_run  = fill_q;
  assign fill_word = fill_value;
`else
  assign fill_go   = 1'b0;
  assign fill_run  = 1'b0;
  assign fill_word = '0;
`endif
  // a fill never reads, so its source alignment is irrelevant
  assign bad = (!fill_go && src_addr[1:0] != 2'b00) || dst_addr[1:0] != 2'b00 ||
               len > LEN_W'(MAX_WORDS);
  dmem_copy_addr_gen #(.AW(AW), .LEN_W(LEN_W)) u_addr (
    .clk     (clk),
    .reset   (reset),
    .load_i  (accept),
    .inc_i   (state_q == WR),
    .nxt_i   (state_q == WR),
    .src_i   (src_addr),
    .dst_i   (dst_addr),
    .len_i   (len),
    .src_a_o (src_a),
    .dst_a_o (dst_a),
    .last_o  (last)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      memwrite_q  <= 1'b0;
      dataaddr_q  <= '0;
      writedata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (bad) begin
            err_q <= 1'b1;
          end else if (len == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b1;
            done_q  <= 1'b1;
          end else if (fill_go) begin
            state_q     <= WR;
            busy_q      <= 1'b1;
            dataaddr_q  <= dst_addr;
            writedata_q <= fill_word;
            memwrite_q  <= 1'b1;
          end else begin
            state_q    <= RD;
            busy_q     <= 1'b1;
            dataaddr_q <= src_addr;
          end
        end
        RD: begin
          state_q     <= WR;
          dataaddr_q  <= dst_a;
          writedata_q <= readdata;
          memwrite_q  <= 1'b1;
        end
        WR: if (last) begin
          state_q    <= DONE;
          memwrite_q <= 1'b0;
          done_q     <= 1'b1;
        end else if (fill_run) begin
          dataaddr_q <= dst_a;
        end else begin
          state_q    <= RD;
          dataaddr_q <= src_a;
          memwrite_q <= 1'b0;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign memwrite  = memwrite_q;
  assign dataaddr  = dataaddr_q;
  assign writedata = writedata_q;
endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb_dmem_copy_engine: directed bench with a 64-word dmem model and a write scoreboard
module tb_dmem_copy_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [6:0]  len = '0;
  logic        busy, done, err, memwrite;
  logic [31:0] dataaddr, writedata, readdata;
`ifdef COPY_FILL_EN
  logic        fill = 1'b0;
  logic [31:0] fill_value = '0;
`endif
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  logic [63:0] exp_q [$];
  int          total = 0, bad = 0, wr_cnt = 0;
  int          done_at, done_cnt, busy_cnt, err_at, err_cnt, w0;

  dmem_copy_engine dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
`ifdef COPY_FILL_EN
    .fill       (fill),
    .fill_value (fill_value),
`endif
    .busy       (busy),
    .done       (done),
    .err        (err),
    .memwrite   (memwrite),
    .dataaddr   (dataaddr),
    .writedata  (writedata),
    .readdata   (readdata)
  );

  always #5 clk = ~clk;
  assign readdata = mem[dataaddr[7:2]];
  always @(posedge clk)
    if (memwrite) mem[dataaddr[7:2]] <= writedata;
    else if (pl_en) mem[pl_idx] <= pl_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (reset && memwrite) begin
      wr_cnt++;
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", dataaddr, e[63:32]);
        check("wr_data", writedata, e[31:0]);
      end
    end

  task automatic poke(input int idx, input logic [31:0] v);
    pl_idx = 6'(idx); pl_data = v; pl_en = 1'b1; ref_mem[idx] = v;
    @(posedge clk); #1 pl_en = 1'b0;
  endtask

  // reference forward copy: reads see earlier writes of the same transfer
  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] v;
      v = ref_mem[(s[7:2] + k) % 64];
      ref_mem[(d[7:2] + k) % 64] = v;
      exp_q.push_back({d + 32'(4 * k), v});
    end
  endtask

  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [6:0] n,
                     input logic f, input logic [31:0] fv);
    done_at = -1; err_at = -1; done_cnt = 0; busy_cnt = 0; err_cnt = 0;
    @(posedge clk); #1
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
`ifdef COPY_FILL_EN
    fill = f; fill_value = fv;
`endif
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; if (done_at < 0) done_at = k; end
      if (err) begin err_cnt++; if (err_at < 0) err_at = k; end
      if ((done_at > 0 && k >= done_at + 2) || (err_at > 0 && k >= err_at + 2)) break;
      @(posedge clk); #1;
    end
    if (f && fv == 32'h1) $display("fill run");
  endtask

  initial begin
    #3;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_memwrite", 32'(memwrite), 0);
    check("rst_dataaddr", dataaddr, 0);
    check("rst_writedata", writedata, 0);
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 64; i++) poke(i, 32'h0);
    for (int i = 0; i < 4; i++) poke(i, 32'hA0A0_0000 | 32'(i));

    push_copy(32'h00, 32'h40, 4);
    run(32'h00, 32'h40, 7'd4, 1'b0, 32'h0);
    check("copy4_latency", done_at, 9);
    check("copy4_done_cnt", done_cnt, 1);
    check("copy4_busy_cycles", busy_cnt, 9);
    check("copy4_err_cnt", err_cnt, 0);
    check("copy4_writes_left", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      check("copy4_src_kept", mem[i], 32'hA0A0_0000 | 32'(i));
      check("copy4_dst", mem[16 + i], 32'hA0A0_0000 | 32'(i));
    end

    w0 = wr_cnt;
    run(32'h00, 32'h40, 7'd0, 1'b0, 32'h0);
    check("len0_latency", done_at, 1);
    check("len0_busy_cycles", busy_cnt, 1);
    check("len0_no_write", wr_cnt, w0);

    run(32'h02, 32'h40, 7'd2, 1'b0, 32'h0);
    check("misalign_err_at", err_at, 1);
    check("misalign_err_cnt", err_cnt, 1);
    check("misalign_busy", busy_cnt, 0);
    check("misalign_done", done_cnt, 0);
    run(32'h00, 32'h40, 7'd65, 1'b0, 32'h0);
    check("len65_err_at", err_at, 1);
    check("len65_err_cnt", err_cnt, 1);
    check("len65_busy", busy_cnt, 0);
    check("err_no_write", wr_cnt, w0);

    poke(0, 32'd11);
    poke(1, 32'd22);
    push_copy(32'h00, 32'h04, 2);
    run(32'h00, 32'h04, 7'd2, 1'b0, 32'h0);
    check("overlap_latency", done_at, 5);
    check("overlap_mem1", mem[1], 32'd11);
    check("overlap_mem2", mem[2], 32'd11);

    push_copy(32'h00, 32'h80, 2);
    w0 = wr_cnt;
    @(posedge clk); #1 src_addr = 32'h00; dst_addr = 32'h80; len = 7'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 40 && wr_cnt < w0 + 2; k++) @(negedge clk);
    check("abort_two_writes", wr_cnt, w0 + 2);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_memwrite", 32'(memwrite), 0);
    check("abort_dataaddr", dataaddr, 0);
    check("abort_writedata", writedata, 0);
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin @(negedge clk); if (done) done_cnt++; end
    check("abort_no_done", done_cnt, 0);
    check("abort_w0", mem[32], ref_mem[32]);
    check("abort_w1", mem[33], ref_mem[33]);
    check("abort_w2_untouched", mem[34], 32'h0);
    check("abort_w3_untouched", mem[35], 32'h0);
    check("abort_sb_drained", exp_q.size(), 0);
    @(negedge clk) reset = 1'b1;
    push_copy(32'h0C, 32'h90, 1);
    run(32'h0C, 32'h90, 7'd1, 1'b0, 32'h0);
    check("post_reset_latency", done_at, 3);
    check("post_reset_mem", mem[36], 32'hA0A0_0003);

`ifdef COPY_FILL_EN
    for (int k = 0; k < 3; k++) exp_q.push_back({32'h80 + 32'(4 * k), 32'hDEAD_BEEF});
    run(32'h01, 32'h80, 7'd3, 1'b1, 32'hDEAD_BEEF);
    check("fill_latency", done_at, 4);
    check("fill_busy_cycles", busy_cnt, 4);
    check("fill_mem34", mem[34], 32'hDEAD_BEEF);
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
